// File: rtl/eth_rx_frame_buffer.sv
// Receive-side Ethernet frame filter and store-and-forward buffer: accepts IPv4 frames
// addressed to LOCAL_MAC or broadcast and exposes whole committed packets through a FWFT read port.
module eth_rx_frame_buffer #(
  parameter logic [47:0] LOCAL_MAC = 48'h020000000001,
  parameter int          ADDR_W    = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  mac_data,
  input  logic        mac_valid,
  input  logic        mac_first,
  input  logic        mac_last,
  input  logic        mac_error,
  input  logic        rd_en,
  output logic [7:0]  rddata,
  output logic        rd_first,
  output logic        rd_last,
  output logic        rx_empty,
  output logic [15:0] frame_ok_count,
  output logic [15:0] frame_drop_count
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HDR     = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_DROP    = 2'd3;

  // Entry layout: {last, first, data}
  logic [9:0]        mem [DEPTH];
  logic [1:0]        state, state_nxt;
  logic [3:0]        hdr_idx, hdr_idx_nxt;
  logic              ucast_ok, bcast_ok, ucast_nxt, bcast_nxt;
  logic [ADDR_W-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic [ADDR_W-1:0] wr_ptr_nxt, commit_ptr_nxt, wr_ptr_inc;
  logic              full, mem_we, ok_inc;
  logic [1:0]        drop_add;
  logic [3:0]        hdr_sel;
  logic              hdr_u, hdr_b, hdr_pass;
  logic [9:0]        head;

  function automatic logic [7:0] mac_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    mac_byte = LOCAL_MAC[47:40];
      4'd1:    mac_byte = LOCAL_MAC[39:32];
      4'd2:    mac_byte = LOCAL_MAC[31:24];
      4'd3:    mac_byte = LOCAL_MAC[23:16];
      4'd4:    mac_byte = LOCAL_MAC[15:8];
      default: mac_byte = LOCAL_MAC[7:0];
    endcase
  endfunction

  assign wr_ptr_inc = wr_ptr + 1'b1;
  assign full       = (wr_ptr_inc == rd_ptr);

  // A byte carrying mac_first is always judged as header byte 0 with fresh match flags.
  assign hdr_sel = mac_first ? 4'd0 : hdr_idx;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    hdr_u    = mac_first | ucast_ok;
    hdr_b    = mac_first | bcast_ok;
    hdr_pass = 1'b1;
    if (hdr_sel < 4'd6) begin
      hdr_u    = hdr_u & (mac_data == mac_byte(hdr_sel));
      hdr_b    = hdr_b & (mac_data == 8'hFF);
      hdr_pass = hdr_u | hdr_b;
    end else if (hdr_sel == 4'd12) begin
      hdr_pass = (mac_data == 8'h08);
    end else if (hdr_sel == 4'd13) begin
      hdr_pass = (mac_data == 8'h00);
    end
  end

  always_comb begin
    state_nxt      = state;
    hdr_idx_nxt    = hdr_idx;
    ucast_nxt      = ucast_ok;
    bcast_nxt      = bcast_ok;
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    ok_inc         = 1'b0;
    drop_add       = 2'd0;
    mem_we         = 1'b0;
    if (mac_valid) begin
      if (mac_first) begin
        // Abandon any partial frame, then treat this byte as byte 0 of a new one.
        if (state == S_HDR || state == S_PAYLOAD) drop_add = 2'd1;
        if (!hdr_pass || mac_last) begin
          drop_add    = drop_add + 2'd1;
          state_nxt   = mac_last ? S_IDLE : S_DROP;
          hdr_idx_nxt = 4'd0;
        end else begin
          state_nxt   = S_HDR;
          hdr_idx_nxt = 4'd1;
          ucast_nxt   = hdr_u;
          bcast_nxt   = hdr_b;
        end
      end else begin
        case (state)
          S_HDR: begin
            if (!hdr_pass || mac_last) begin
              drop_add    = 2'd1;
              state_nxt   = mac_last ? S_IDLE : S_DROP;
              hdr_idx_nxt = 4'd0;
            end else if (hdr_idx == 4'd13) begin
              state_nxt   = S_PAYLOAD;
              hdr_idx_nxt = 4'd0;
            end else begin
              hdr_idx_nxt = hdr_idx + 4'd1;
              ucast_nxt   = hdr_u;
              bcast_nxt   = hdr_b;
            end
          end
          S_PAYLOAD: begin
            if (full) begin
              drop_add  = 2'd1;
              state_nxt = mac_last ? S_IDLE : S_DROP;
            end else begin
              mem_we     = 1'b1;
              wr_ptr_nxt = wr_ptr_inc;
              if (mac_last) begin
                state_nxt = S_IDLE;
                if (mac_error) begin
                  drop_add = 2'd1;
                end else begin
                  commit_ptr_nxt = wr_ptr_inc;
                  ok_inc         = 1'b1;
                end
              end
            end
          end
          S_DROP: begin
            if (mac_last) state_nxt = S_IDLE;
          end
          default: ;
        endcase
      end
      if (drop_add != 2'd0) wr_ptr_nxt = commit_ptr;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state            <= S_IDLE;
      hdr_idx          <= 4'd0;
      ucast_ok         <= 1'b0;
      bcast_ok         <= 1'b0;
      wr_ptr           <= '0;
      commit_ptr       <= '0;
      rd_ptr           <= '0;
      frame_ok_count   <= 16'd0;
      frame_drop_count <= 16'd0;
    end else begin
      state            <= state_nxt;
      hdr_idx          <= hdr_idx_nxt;
      ucast_ok         <= ucast_nxt;
      bcast_ok         <= bcast_nxt;
      wr_ptr           <= wr_ptr_nxt;
      commit_ptr       <= commit_ptr_nxt;
      frame_ok_count   <= frame_ok_count + 16'(ok_inc);
      frame_drop_count <= frame_drop_count + 16'(drop_add);
      if (rd_en && !rx_empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= {mac_last, (wr_ptr == commit_ptr), mac_data};
  end

  assign head     = mem[rd_ptr];
  assign rx_empty = (rd_ptr == commit_ptr);
  assign rddata   = rx_empty ? 8'h00 : head[7:0];
  assign rd_first = rx_empty ? 1'b0 : head[8];
  assign rd_last  = rx_empty ? 1'b0 : head[9];

endmodule

// File: doc/eth_rx_frame_buffer.md
ETH_RX_FRAME_BUFFER -- requirements
Module: eth_rx_frame_buffer

Interface
REQ-001 Parameter LOCAL_MAC, default 48'h020000000001, unicast MAC address accepted by the block.
REQ-002 Parameter ADDR_W, default 11, log2 of buffer depth in entries (2048 entries of 10 bits: data, first tag, last tag).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 mac_data  input  8  received Ethernet byte (FCS already stripped).
REQ-006 mac_valid  input  1  mac_data qualifier; no backpressure.
REQ-007 mac_first  input  1  first byte of frame, qualified by mac_valid.
REQ-008 mac_last  input  1  last byte of frame, qualified by mac_valid.
REQ-009 mac_error  input  1  frame bad; sampled only with mac_valid and mac_last.
REQ-010 rd_en  input  1  downstream pop of the head entry.
REQ-011 rddata  output  8  head entry data byte (IPv4 packet byte).
REQ-012 rd_first  output  1  head entry is first byte of an IPv4 packet.
REQ-013 rd_last  output  1  head entry is last byte of an IPv4 packet.
REQ-014 rx_empty  output  1  no committed entry available.
REQ-015 frame_ok_count  output  16  committed frames, wraps at 16'hFFFF.
REQ-016 frame_drop_count  output  16  dropped frames, wraps at 16'hFFFF.

Function
REQ-017 Write FSM states SHALL be IDLE, HDR, PAYLOAD, DROP; byte index counter hdr_idx 0..13 used in HDR.
REQ-018 IDLE: mac_valid & mac_first -> HDR with hdr_idx=1 after checking byte 0; mac_valid without mac_first ignored.
REQ-019 HDR bytes 0-5 SHALL equal LOCAL_MAC (MSB first) or all 8'hFF; bytes 12-13 SHALL equal 8'h08, 8'h00; any mismatch -> DROP; header bytes never written to buffer.
REQ-020 HDR byte 13 matching -> PAYLOAD; next payload byte written with first tag set.
REQ-021 PAYLOAD: each valid byte written at wr_ptr with first/last tags, wr_ptr increments mod 2^ADDR_W.
REQ-022 Commit: valid byte with mac_last and !mac_error, written without overflow -> commit_ptr <= wr_ptr+1, frame_ok_count+1, state IDLE.
REQ-023 Rollback: mac_error on last, overflow, header mismatch, or mac_last while in HDR (runt <15 bytes) -> wr_ptr <= commit_ptr, frame_drop_count+1 exactly once per frame.
REQ-024 Overflow: buffer full when wr_ptr+1 == rd_ptr; byte arriving when full is discarded and frame rolled back.
REQ-025 DROP: discard bytes until mac_last, then IDLE; if the rolling-back byte carries mac_last, go directly to IDLE.
REQ-026 mac_first in HDR/PAYLOAD/DROP: current frame rolled back (drop counted unless already in DROP) and byte processed as byte 0 of new frame.
REQ-027 Read side first-word-fall-through: rx_empty = (rd_ptr == commit_ptr); when !rx_empty outputs show entry at rd_ptr combinationally.
REQ-028 rd_en & !rx_empty -> rd_ptr+1 next cycle; rd_en while rx_empty ignored.
REQ-029 rddata, rd_first, rd_last SHALL be 0 whenever rx_empty=1.
REQ-030 Uncommitted bytes SHALL never be visible to the read side; simultaneous commit and pop both take effect in the same cycle.
REQ-031 Latency: last byte of a good frame at cycle N -> rx_empty=0 at cycle N+1.

Reset
REQ-032 rst_n=0 at a clock edge: state IDLE, wr_ptr=commit_ptr=rd_ptr=0, hdr_idx=0, both counters 0, rx_empty=1, rddata/rd_first/rd_last=0.
REQ-033 Reset mid-frame discards partial and committed data; no counter increment; buffer memory contents need not clear.

Verification
REQ-034 Frame dst 02:00:00:00:00:01, type 0800, 20-byte payload 8'h45..  -> 20 entries, first on 8'h45, last on byte 20, ok_count=1, rx_empty=0 one cycle after mac_last.
REQ-035 Broadcast dst FF:FF:FF:FF:FF:FF, type 0806 -> nothing written, rx_empty stays 1, drop_count=1.
REQ-036 Good 30-byte-payload frame with mac_error=1 on last -> rx_empty stays 1, drop_count=1, following good frame read intact with correct first tag.
REQ-037 ADDR_W=4, 20-byte payload with rd_en=0 -> overflow at 16th byte, rollback, drop_count=1, rx_empty=1; subsequent 10-byte frame committed.
REQ-038 mac_first at payload byte 5 of frame A, frame B good -> only B's bytes readable, drop_count=1, ok_count=1.
REQ-039 rst_n=0 for one cycle with 2 committed frames unread -> rx_empty=1, counters 0, rddata=0 next cycle.
